// File: rtl/chkrpl_pkg.sv
// Shared constants and types for the chkrpl_arb round-robin pipeline sequencer.
package chkrpl_pkg;
  localparam int unsigned DW       = 4;
  localparam int unsigned LAT      = 3;
  localparam int unsigned IDLE_VAL = 10;
  // Tag id is sized for the largest supported requester count (8).
  localparam int unsigned IDW_MAX  = 3;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic               v;
    logic [IDW_MAX-1:0] id;
  } tag_t;
endpackage

// File: rtl/chkrpl_rr_pick.sv
// Combinational round-robin pick: first set request after ptr_i, with wrap-around.
module chkrpl_rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
endmodule

// File: rtl/chkrpl_arb.sv
// Round-robin arbiter feeding a shared fixed-latency pipeline, with ID tag pipe and flush/drain FSM.
// Optional per-requester grant counters are built when CHKRPL_ARB_PERF_EN is defined.
module chkrpl_arb #(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned DW       = chkrpl_pkg::DW,
  parameter  int unsigned LAT      = chkrpl_pkg::LAT,
  parameter  int unsigned IDLE_VAL = chkrpl_pkg::IDLE_VAL,
  localparam int unsigned IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      pl_d_in,
  input  logic [DW-1:0]      pl_d_out,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy,
  input  logic               test_mode,
  input  logic               scan_en,
  input  logic               scan_in0,
  output logic               scan_out0
`ifdef CHKRPL_ARB_PERF_EN
  ,
  input  logic [IDW-1:0]     perf_sel,
  output logic [15:0]        perf_cnt
`endif
);
  import chkrpl_pkg::*;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  tag_t           tag_q [LAT];
  logic           grant_en;
  logic           accept;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_idx;
  logic           unused_bits;

  // Grants only in RUN and never in the cycle flush is first seen.
  assign grant_en = (state_q == RUN) && !flush && !reset;

  chkrpl_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid & {NREQ{grant_en}}),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (accept)
  );

  assign req_ready = gnt;
  assign pl_d_in   = accept ? req_data[gnt_idx*DW +: DW] : DW'(IDLE_VAL);
  assign rr_ptr_d  = accept ? gnt_idx : rr_ptr_q;

  assign rsp_valid = tag_q[LAT-1].v;
  assign rsp_id    = tag_q[LAT-1].id[IDW-1:0];
  assign rsp_data  = pl_d_out;
  assign scan_out0 = 1'b0;
  assign unused_bits = ^{test_mode, scan_en, scan_in0, tag_q[LAT-1].id};

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) busy = busy | tag_q[i].v;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (!busy) begin
               flush_done = 1'b1;
               state_d    = DONE;
             end
      DONE:  if (!flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      rr_ptr_q <= IDW'(NREQ - 1);
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= '{v: accept, id: IDW_MAX'(gnt_idx)};
      for (int unsigned i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef CHKRPL_ARB_PERF_EN
  localparam int unsigned NSLOT = 2**IDW;
  logic [15:0]      cnt_q [NSLOT];
  logic [NSLOT-1:0] gnt_ext;

  // Slots above NREQ exist only so perf_sel can never index out of range; they stay zero.
  assign gnt_ext  = NSLOT'(gnt);
  assign perf_cnt = cnt_q[perf_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSLOT; i++) cnt_q[i] <= '0;
    end else if (flush_done) begin
      for (int unsigned i = 0; i < NSLOT; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NSLOT; i++)
        if (gnt_ext[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_chkrpl_arb.sv
// Directed bench for chkrpl_arb with a 3-stage register pipeline model reset to 10.
module tb_chkrpl_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  pl_d_in, pl_d_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        flush = 1'b0;
  logic        flush_done, busy;
  logic        scan_out0;
`ifdef CHKRPL_ARB_PERF_EN
  logic [1:0]  perf_sel = '0;
  logic [15:0] perf_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  chkrpl_arb #(.NREQ(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pl_d_in(pl_d_in), .pl_d_out(pl_d_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .test_mode(1'b0), .scan_en(1'b0), .scan_in0(1'b0), .scan_out0(scan_out0)
`ifdef CHKRPL_ARB_PERF_EN
    , .perf_sel(perf_sel), .perf_cnt(perf_cnt)
`endif
  );

  logic [3:0] pipe [3];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] <= 4'd10;
    end else begin
      pipe[0] <= pl_d_in;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end
  assign pl_d_out = pipe[2];

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] data;
    logic        fl;
    logic [3:0]  rdy;
    logic [3:0]  pin;
    logic        rv;
    logic [1:0]  rid;
    logic [3:0]  rd;
    logic        bsy;
    logic        fd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] vld, input logic [15:0] data, input logic fl,
                     input logic [3:0] rdy, input logic [3:0] pin, input logic rv,
                     input logic [1:0] rid, input logic [3:0] rd, input logic bsy,
                     input logic fd);
    vq.push_back('{vld, data, fl, rdy, pin, rv, rid, rd, bsy, fd});
  endtask

  task automatic chk(input string nm, input int cyc, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] D = 16'h4321;

  initial begin
    // one record per cycle: inputs, then ready, pl_d_in, rsp_valid/id/data, busy, flush_done
    add(4'b0010, 16'h0050, 0, 4'b0010, 4'd5,  0, 0, 0, 0, 0);
    add(4'b0000, 16'h0000, 0, 4'b0000, 4'd10, 0, 0, 0, 1, 0);
    add(4'b0000, 16'h0000, 0, 4'b0000, 4'd10, 0, 0, 0, 1, 0);
    add(4'b0000, 16'h0000, 0, 4'b0000, 4'd10, 1, 1, 5, 1, 0);
    add(4'b1000, D,        0, 4'b1000, 4'd4,  0, 0, 0, 0, 0);
    add(4'b1111, D,        0, 4'b0001, 4'd1,  0, 0, 0, 1, 0);
    add(4'b1111, D,        0, 4'b0010, 4'd2,  0, 0, 0, 1, 0);
    add(4'b1111, D,        0, 4'b0100, 4'd3,  1, 3, 4, 1, 0);
    add(4'b1111, D,        0, 4'b1000, 4'd4,  1, 0, 1, 1, 0);
    add(4'b1111, D,        0, 4'b0001, 4'd1,  1, 1, 2, 1, 0);
    add(4'b0101, D,        0, 4'b0100, 4'd3,  1, 2, 3, 1, 0);
    add(4'b0101, D,        0, 4'b0001, 4'd1,  1, 3, 4, 1, 0);
    add(4'b0101, D,        0, 4'b0100, 4'd3,  1, 0, 1, 1, 0);
    add(4'b0101, D,        0, 4'b0001, 4'd1,  1, 2, 3, 1, 0);
    add(4'b0101, D,        1, 4'b0000, 4'd10, 1, 0, 1, 1, 0);
    add(4'b0101, D,        1, 4'b0000, 4'd10, 1, 2, 3, 1, 0);
    add(4'b0101, D,        1, 4'b0000, 4'd10, 1, 0, 1, 1, 0);
    add(4'b0101, D,        1, 4'b0000, 4'd10, 0, 0, 0, 0, 1);
    add(4'b0101, D,        1, 4'b0000, 4'd10, 0, 0, 0, 0, 0);
    add(4'b0101, D,        1, 4'b0000, 4'd10, 0, 0, 0, 0, 0);
    add(4'b0101, D,        0, 4'b0000, 4'd10, 0, 0, 0, 0, 0);
    add(4'b0101, D,        0, 4'b0100, 4'd3,  0, 0, 0, 0, 0);
    add(4'b0101, D,        0, 4'b0001, 4'd1,  0, 0, 0, 1, 0);
    add(4'b0000, D,        0, 4'b0000, 4'd10, 0, 0, 0, 1, 0);
    add(4'b0000, D,        0, 4'b0000, 4'd10, 1, 2, 3, 1, 0);
    add(4'b0000, D,        0, 4'b0000, 4'd10, 1, 0, 1, 1, 0);
    add(4'b0000, D,        0, 4'b0000, 4'd10, 0, 0, 0, 0, 0);
    add(4'b0000, D,        1, 4'b0000, 4'd10, 0, 0, 0, 0, 0);
    add(4'b0000, D,        1, 4'b0000, 4'd10, 0, 0, 0, 0, 1);
    add(4'b0000, D,        0, 4'b0000, 4'd10, 0, 0, 0, 0, 0);
    add(4'b0000, D,        0, 4'b0000, 4'd10, 0, 0, 0, 0, 0);

    // reset state, with requests present
    req_valid = 4'b1111;
    req_data  = D;
    @(negedge clk);
    chk("rst_ready", -1, 16'(req_ready), 16'h0);
    chk("rst_pl_d_in", -1, 16'(pl_d_in), 16'd10);
    chk("rst_rsp_valid", -1, 16'(rsp_valid), 16'h0);
    chk("rst_rsp_id", -1, 16'(rsp_id), 16'h0);
    chk("rst_busy", -1, 16'(busy), 16'h0);
    chk("rst_flush_done", -1, 16'(flush_done), 16'h0);
    chk("scan_out0", -1, 16'(scan_out0), 16'h0);
    step();
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      req_valid = vq[i].vld;
      req_data  = vq[i].data;
      flush     = vq[i].fl;
      @(negedge clk);
      chk("ready", i, 16'(req_ready), 16'(vq[i].rdy));
      chk("pl_d_in", i, 16'(pl_d_in), 16'(vq[i].pin));
      chk("rsp_valid", i, 16'(rsp_valid), 16'(vq[i].rv));
      if (vq[i].rv) begin
        chk("rsp_id", i, 16'(rsp_id), 16'(vq[i].rid));
        chk("rsp_data", i, 16'(rsp_data), 16'(vq[i].rd));
      end
      chk("busy", i, 16'(busy), 16'(vq[i].bsy));
      chk("flush_done", i, 16'(flush_done), 16'(vq[i].fd));
      step();
    end

    // reset with two words in flight; pointer last at 0
    req_valid = 4'b0010;
    @(negedge clk);
    chk("pre_rst_grant1", 100, 16'(req_ready), 16'b0010);
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("pre_rst_grant2", 101, 16'(req_ready), 16'b0100);
    step();
    req_valid = 4'b1111;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_rst_rsp_valid", 102 + c, 16'(rsp_valid), 16'h0);
      chk("mid_rst_ready", 102 + c, 16'(req_ready), 16'h0);
      chk("mid_rst_busy", 102 + c, 16'(busy), 16'h0);
      step();
    end
    reset = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("post_rst_grant", 106, 16'(req_ready), 16'b0010);
    chk("post_rst_pl_d_in", 106, 16'(pl_d_in), 16'd2);
    chk("post_rst_rsp_valid", 106, 16'(rsp_valid), 16'h0);
    step();
    req_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 107 + c, 16'(rsp_valid), 16'h0);
      step();
    end
    @(negedge clk);
    chk("post_rst_rsp_valid", 109, 16'(rsp_valid), 16'h1);
    chk("post_rst_rsp_id", 109, 16'(rsp_id), 16'h1);
    chk("post_rst_rsp_data", 109, 16'(rsp_data), 16'h2);
    step();

`ifdef CHKRPL_ARB_PERF_EN
    perf_sel = 2'd1;
    #1;
    chk("perf_cnt1", 200, perf_cnt, 16'd1);
    perf_sel = 2'd0;
    req_valid = 4'b0001;
    for (int c = 0; c < 100; c++) @(posedge clk);
    #1;
    chk("perf_cnt0_100", 201, perf_cnt, 16'd100);
    for (int c = 0; c < 69900; c++) @(posedge clk);
    #1;
    chk("perf_cnt0_sat", 202, perf_cnt, 16'hFFFF);
    req_valid = 4'b0000;
    flush = 1'b1;
    begin
      int n = 0;
      while (!flush_done && n < 10) begin
        step();
        n++;
      end
      chk("perf_flush_done_seen", 203, 16'(flush_done), 16'h1);
    end
    step();
    chk("perf_cnt0_clr", 204, perf_cnt, 16'h0);
    perf_sel = 2'd1;
    #1;
    chk("perf_cnt1_clr", 205, perf_cnt, 16'h0);
    flush = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
